// File: rtl/mul_su_seq.sv
// Sequential signed x unsigned multiplier: one radix-4 digit of u per cycle, valid/ready on both sides.
// Optional macro MUL_SU_SIGNED_U_EN adds u_signed, treating u as two's complement (top digit signed).
module mul_su_seq #(
  parameter int W_S = 8,
  parameter int W_U = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_S-1:0]       s,
  input  logic [W_U-1:0]       u,
`ifdef MUL_SU_SIGNED_U_EN
  input  logic                 u_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_S+W_U-1:0]   out,
  output logic                 busy
);

  localparam int W  = W_S + W_U;
  localparam int ND = W_U / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_s;
  logic [W_U-1:0]  r_u;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_out;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
`ifdef MUL_SU_SIGNED_U_EN
  logic            r_u_signed;
`endif

  logic [1:0]      w_digit;
  logic            w_last;
  logic [W-1:0]    w_pp;
  logic [W-1:0]    w_sum;

  assign w_digit = r_u[{r_cnt, 1'b0} +: 2];
  assign w_last  = (r_cnt == CW'(ND - 1));

  // Digit multiple {0, s, 2s, 3s}; in signed-u mode the top digit maps to {0, s, -2s, -s}.
  always_comb begin
    w_pp = '0;
    case (w_digit)
      2'd1:    w_pp = r_s;
      2'd2:    w_pp = r_s << 1;
      2'd3:    w_pp = r_s + (r_s << 1);
      default: w_pp = '0;
    endcase
`ifdef MUL_SU_SIGNED_U_EN
    if (r_u_signed && w_last) begin
      if (w_digit == 2'd2) w_pp = -(r_s << 1);
      if (w_digit == 2'd3) w_pp = -r_s;
    end
`endif
  end

  assign w_sum = r_acc + (w_pp << {r_cnt, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_u         <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MUL_SU_SIGNED_U_EN
      r_u_signed  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s        <= {{W_U{s[W_S-1]}}, s};
            r_u        <= u;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef MUL_SU_SIGNED_U_EN
            r_u_signed <= u_signed;
`endif
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_out       <= w_sum;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out       = r_out;

endmodule

// File: tb/tb_mul_su_seq.sv
// Randomised + directed bench for mul_su_seq: an 8x8 instance and a 2x2 instance, checked against integer products.
module tb_mul_su_seq;

`ifdef MUL_SU_SIGNED_U_EN
  localparam bit HAS_US = 1'b1;
`else
  localparam bit HAS_US = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy, us;
  logic [7:0]  s, u;
  logic [15:0] out;

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_busy;
  logic [1:0]  d2_s, d2_u;
  logic [3:0]  d2_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] got;

  always #5 clk = ~clk;

  mul_su_seq #(.W_S(8), .W_U(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .u(u),
`ifdef MUL_SU_SIGNED_U_EN
    .u_signed(us),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  mul_su_seq #(.W_S(2), .W_U(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .s(d2_s), .u(d2_u),
`ifdef MUL_SU_SIGNED_U_EN
    .u_signed(1'b0),
`endif
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out(d2_out), .busy(d2_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ref_mul(input logic [7:0] a, input logic [7:0] b, input bit bs);
    longint x, y;
    x = longint'($signed(a));
    y = (bs && HAS_US) ? longint'($signed(b)) : longint'(b);
    return x * y;
  endfunction

  task automatic run8(input logic [7:0] sa, input logic [7:0] ua, input bit usa, input int bp,
                      output logic [15:0] res);
    int lat;
    longint m;
    logic [15:0] held;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    s = sa; u = ua; us = usa; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; s = 8'($urandom); u = 8'($urandom); us = 1'($urandom);
    check("busy", 32'(busy), 32'd1);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'd4);
    m = ref_mul(sa, ua, usa);
    check("product", 32'(out), 32'(m[15:0]));
    held = out;
    for (int k = 0; k < bp; k++) begin
      check("hold_out", 32'(out), 32'(held));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("in_ready_done", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_clear", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("out_kept", 32'(out), 32'(held));
    res = held;
    $display("job8 s=%h u=%h us=%0d bp=%0d out=%h lat=%0d", sa, ua, usa, bp, held, lat);
  endtask

  task automatic run2(input logic [1:0] sa, input logic [1:0] ua);
    int lat;
    longint m;
    check("d2_in_ready", 32'(d2_in_ready), 32'd1);
    d2_s = sa; d2_u = ua; d2_in_valid = 1'b1;
    tick();
    d2_in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!d2_out_valid && lat < 10);
    check("d2_latency", 32'(lat), 32'd1);
    m = longint'($signed(sa)) * longint'(ua);
    check("d2_product", 32'(d2_out), 32'(m[3:0]));
    d2_out_ready = 1'b1;
    tick();
    d2_out_ready = 1'b0;
    check("d2_valid_clear", 32'(d2_out_valid), 32'd0);
    $display("job2 s=%b u=%b out=%b lat=%0d", sa, ua, d2_out, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; us = 1'b0; s = '0; u = '0;
    d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_s = '0; d2_u = '0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    rst = 1'b0;
    tick();

    // Reset lands asynchronously in the second BUSY cycle and discards the job.
    s = 8'h55; u = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_output", 32'(out_valid), 32'd0);
      tick();
    end
    run8(8'h55, 8'h03, 1'b0, 0, got);
    check("after_rst_55x03", 32'(got), 32'h00FF);

    run8(8'h80, 8'hFF, 1'b0, 0, got);
    check("extreme_80xFF", 32'(got), 32'h8080);
    run8(8'hFF, 8'h01, 1'b0, 1, got);
    check("neg1x1", 32'(got), 32'hFFFF);
    run8(8'h7F, 8'hFF, 1'b0, 5, got);
    check("maxpos", 32'(got), 32'h7E81);
    run8(8'h00, 8'hAB, 1'b0, 0, got);
    check("s_zero", 32'(got), 32'h0000);
    run8(8'h9C, 8'h00, 1'b0, 2, got);
    check("u_zero", 32'(got), 32'h0000);
    run8(8'h03, 8'h80, 1'b0, 0, got);
    check("u_unsigned_03x80", 32'(got), 32'h0180);
`ifdef MUL_SU_SIGNED_U_EN
    run8(8'h03, 8'h80, 1'b1, 0, got);
    check("u_signed_03x80", 32'(got), 32'hFE80);
`endif

    for (int j = 0; j < 40; j++)
      run8(8'($urandom), 8'($urandom), HAS_US ? 1'($urandom) : 1'b0, int'($urandom_range(0, 3)), got);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        run2(2'(a), 2'(b));
    d2_s = 2'b10; d2_u = 2'b11;
    run2(d2_s, d2_u);
    check("d2_cell_10x11", 32'(d2_out), 32'b1010);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
